// File: rtl/bcd_display_scan.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_display_scan
//  Purpose  : Captures a 5-digit packed BCD result on the rising edge of the
//             converter's done and time-multiplexes it onto a common-anode
//             7-segment bank. Includes a programmable scan prescaler,
//             optional leading-zero blanking and an end-of-frame pulse.
//  Revision : 1.0  initial release
// ============================================================================
module bcd_display_scan #(
  parameter int PRESCALE = 50000  // clk cycles per digit slot, 1..2^20-1
) (
  input  logic        clk,
  input  logic        reset,      // asynchronous, active-low
  input  logic [19:0] bcd_in,
  input  logic        done_in,
  input  logic        blank_en,
  output logic [4:0]  an,
  output logic [6:0]  seg,
  output logic        frame
);

  // A single-cycle prescaler still needs a one-bit counter to stay legal.
  localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [2:0]    IDX_LAST = 3'd4;
  localparam logic [4:0]    AN_OFF   = 5'b11111;
  localparam logic [6:0]    SEG_OFF  = 7'b1111111;

  logic [19:0]   shadow_q, shadow_d;
  logic          done_q, done_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [2:0]    idx_q, idx_d;
  logic [4:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          frame_q, frame_d;

  logic          tick;
  logic          blank;
  logic [3:0]    nib;

  // Active-low segment pattern {g,f,e,d,c,b,a}; non-decimal nibbles show 'E'.
  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b0000110;
    endcase
  endfunction

  // Next-state for capture, scan counters and the registered display drive.
  always_comb begin
    done_d   = done_in;
    shadow_d = (done_in && !done_q) ? bcd_in : shadow_q;

    tick  = (pre_q == PRE_LAST);
    pre_d = tick ? '0 : pre_q + 1'b1;
    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
    end else begin
      idx_d = idx_q;
    end
    frame_d = tick && (idx_q == IDX_LAST);

    // Digit currently selected, taken from the pre-capture shadow.
    case (idx_q)
      3'd0:    nib = shadow_q[3:0];
      3'd1:    nib = shadow_q[7:4];
      3'd2:    nib = shadow_q[11:8];
      3'd3:    nib = shadow_q[15:12];
      3'd4:    nib = shadow_q[19:16];
      default: nib = shadow_q[3:0];
    endcase

    // A digit is a leading zero only if it and every digit above it are 0.
    blank = 1'b0;
    if (blank_en && (idx_q != 3'd0)) begin
      blank = 1'b1;
      for (int i = 1; i < 5; i++) begin
        if ((i >= int'(idx_q)) && (shadow_q[4*i +: 4] != 4'd0)) begin
          blank = 1'b0;
        end
      end
    end

    case (idx_q)
      3'd0:    an_d = 5'b11110;
      3'd1:    an_d = 5'b11101;
      3'd2:    an_d = 5'b11011;
      3'd3:    an_d = 5'b10111;
      3'd4:    an_d = 5'b01111;
      default: an_d = AN_OFF;
    endcase
    seg_d = seg_decode(nib);
    if (blank) begin
      an_d  = AN_OFF;
      seg_d = SEG_OFF;
    end
  end

  // State and output registers; reset blanks the display and restarts the scan.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_q <= '0;
      done_q   <= 1'b0;
      pre_q    <= '0;
      idx_q    <= 3'd0;
      an_q     <= AN_OFF;
      seg_q    <= SEG_OFF;
      frame_q  <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      done_q   <= done_d;
      pre_q    <= pre_d;
      idx_q    <= idx_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      frame_q  <= frame_d;
    end
  end

  assign an    = an_q;
  assign seg   = seg_q;
  assign frame = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_display_scan.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bcd_display_scan
//  Purpose  : Self-checking bench for bcd_display_scan at PRESCALE=4 and 1,
//             compared every cycle against a cycle-count based reference.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bcd_display_scan;

  logic        clk;
  logic        reset;
  logic [19:0] bcd_in;
  logic        done_in;
  logic        blank_en;
  logic [4:0]  an4, an1;
  logic [6:0]  seg4, seg1;
  logic        frame4, frame1;

  int n_checks = 0;
  int n_pass   = 0;

  bcd_display_scan #(.PRESCALE(4)) dut4 (
    .clk(clk), .reset(reset), .bcd_in(bcd_in), .done_in(done_in),
    .blank_en(blank_en), .an(an4), .seg(seg4), .frame(frame4)
  );

  bcd_display_scan #(.PRESCALE(1)) dut1 (
    .clk(clk), .reset(reset), .bcd_in(bcd_in), .done_in(done_in),
    .blank_en(blank_en), .an(an1), .seg(seg1), .frame(frame1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Comparison helper: counts every comparison, reports each mismatch.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // ---------------- reference model ----------------
  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0000110, 7'b0000110,
    7'b0000110, 7'b0000110, 7'b0000110, 7'b0000110
  };

  // Display for the edge numbered k after reset release (k=0 is the first).
  function automatic logic [11:0] ref_out(input int unsigned k, input logic [19:0] sh,
                                          input logic ben, input int unsigned p);
    int unsigned d;
    logic [3:0]  n;
    logic [19:0] upper;
    d     = (k / p) % 5;
    n     = sh[4*d +: 4];
    upper = sh >> (4 * d);
    if (ben && (d != 0) && (upper == 20'd0)) return {5'b11111, 7'b1111111};
    return {~(5'b00001 << d), seg_tab[n]};
  endfunction

  int unsigned k;       // edges since reset release
  logic [19:0] m_sh;
  logic        m_pd;
  logic [4:0]  e_an4, e_an1;
  logic [6:0]  e_seg4, e_seg1;
  logic        e_fr4, e_fr1;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      k      <= 0;
      m_sh   <= '0;
      m_pd   <= 1'b0;
      e_an4  <= 5'b11111;  e_seg4 <= 7'b1111111;  e_fr4 <= 1'b0;
      e_an1  <= 5'b11111;  e_seg1 <= 7'b1111111;  e_fr1 <= 1'b0;
    end else begin
      {e_an4, e_seg4} <= ref_out(k, m_sh, blank_en, 4);
      {e_an1, e_seg1} <= ref_out(k, m_sh, blank_en, 1);
      e_fr4 <= ((k % 20) == 19);
      e_fr1 <= ((k % 5) == 4);
      k     <= k + 1;
      m_pd  <= done_in;
      if (done_in && !m_pd) m_sh <= bcd_in;
    end
  end

  // Every cycle, away from the active edge, compare both instances.
  always @(negedge clk) begin
    check("an4",    {27'd0, an4},    {27'd0, e_an4});
    check("seg4",   {25'd0, seg4},   {25'd0, e_seg4});
    check("frame4", {31'd0, frame4}, {31'd0, e_fr4});
    check("an1",    {27'd0, an1},    {27'd0, e_an1});
    check("seg1",   {25'd0, seg1},   {25'd0, e_seg1});
    check("frame1", {31'd0, frame1}, {31'd0, e_fr1});
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic load(input logic [19:0] v, input logic ben);
    bcd_in   = v;
    blank_en = ben;
    done_in  = 1'b1;
    step(1);
    done_in  = 1'b0;
  endtask

  int fc4, fc1;
  int waited;

  initial begin
    reset = 1'b0; bcd_in = '0; done_in = 1'b0; blank_en = 1'b0;
    step(3);
    check("rst_an4_hold",  {27'd0, an4},  32'h1f);
    check("rst_seg4_hold", {25'd0, seg4}, 32'h7f);
    reset = 1'b1;
    step(1);
    #1 check("first_edge_an4", {27'd0, an4}, 32'h1e);

    // 12345 unblanked, then count frame pulses over 40 cycles
    load(20'h12345, 1'b0);
    step(5);
    fc4 = 0; fc1 = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (frame4) fc4++;
      if (frame1) fc1++;
    end
    step(1);
    check("frame_count4", fc4, 2);
    check("frame_count1", fc1, 8);

    // leading-zero blanking on and off
    load(20'h00042, 1'b1);
    step(25);
    blank_en = 1'b0;
    step(25);

    // held done must not recapture
    bcd_in = 20'h0000A; done_in = 1'b1;
    step(50);
    bcd_in = 20'h99999;
    step(30);
    done_in = 1'b0;
    step(5);

    // all-zero with blanking: only digit 0 lit
    load(20'h00000, 1'b1);
    step(25);

    // randomized values, blanking and done patterns
    for (int it = 0; it < 40; it++) begin
      logic [19:0] v;
      int          nz;
      v  = 20'($urandom);
      nz = $urandom_range(0, 5);
      if (nz > 0) v = v & (20'hFFFFF >> (4 * nz));
      if ($urandom_range(0, 1) == 1) begin
        for (int d = 0; d < 5; d++) if (v[4*d +: 4] > 4'd9) v[4*d +: 4] = 4'($urandom_range(0, 9));
      end
      bcd_in   = v;
      blank_en = 1'($urandom);
      case ($urandom_range(0, 2))
        0: begin done_in = 1'b1; step(1); done_in = 1'b0; end
        1: begin done_in = 1'b1; step($urandom_range(2, 8)); bcd_in = 20'($urandom); step(2); done_in = 1'b0; end
        default: begin bcd_in = 20'($urandom); step(1); end
      endcase
      step($urandom_range(5, 30));
    end

    // asynchronous reset in the middle of digit 3's slot (PRESCALE=4)
    waited = 0;
    while (!(((k / 4) % 5 == 3) && (k % 4 == 2)) && waited < 40) begin
      step(1);
      waited++;
    end
    check("idx3_wait_bound", waited < 40, 1);
    reset = 1'b0;
    #1;
    check("async_an4",    {27'd0, an4},    32'h1f);
    check("async_seg4",   {25'd0, seg4},   32'h7f);
    check("async_frame4", {31'd0, frame4}, 32'h0);
    check("async_an1",    {27'd0, an1},    32'h1f);
    step(3);
    reset = 1'b1;
    blank_en = 1'b0;
    step(1);
    #1;
    check("restart_an4",  {27'd0, an4},  32'h1e);
    check("restart_seg4", {25'd0, seg4}, 32'h40);
    step(45);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
